// File: rtl/keypad_matrix_scanner_if.sv
// Keypad scanner pin/report bundle.
// Optional key_release/key_release_code exist only with KEY_RELEASE_EN.
interface keypad_matrix_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int CODE_W = $clog2(ROWS * COLS);

    logic [ROWS-1:0]   buttonsin;
    logic [COLS-1:0]   buttonsout;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_multi;
    logic              key_held;
`ifdef KEY_RELEASE_EN
    logic              key_release;
    logic [CODE_W-1:0] key_release_code;
`endif

    modport master (
        input  buttonsin,
        output buttonsout,
        output key_valid,
        output key_code,
        output key_multi,
`ifdef KEY_RELEASE_EN
        output key_release,
        output key_release_code,
`endif
        output key_held
    );

    modport slave (
        output buttonsin,
        input  buttonsout,
        input  key_valid,
        input  key_code,
        input  key_multi,
`ifdef KEY_RELEASE_EN
        input  key_release,
        input  key_release_code,
`endif
        input  key_held
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// ROWS x COLS keypad scanner with per-column two-sample debounce.
// Define KEY_RELEASE_EN to add release reporting.
module keypad_matrix_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 10,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int CODE_W         = $clog2(ROWS * COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    keypad_matrix_scanner_if.master kp
);
    localparam int MAX_C = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                           SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam int COL_W = $clog2(COLS);

    typedef enum logic [1:0] {
        SETTLE,
        DEBOUNCE,
        EVAL
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [ROWS-1:0]             samp_a_q, samp_a_d;
    logic [ROWS-1:0]             samp_b_q, samp_b_d;
    logic [COLS-1:0][ROWS-1:0]   stable_q, stable_d;
    logic                        valid_q, valid_d;
    logic [CODE_W-1:0]           code_q, code_d;
    logic                        multi_q, multi_d;
    logic                        held_q, held_d;
    logic [ROWS-1:0]             new_keys;
`ifdef KEY_RELEASE_EN
    logic                        rel_q, rel_d;
    logic [CODE_W-1:0]           rel_code_q, rel_code_d;
    logic [ROWS-1:0]             rel_keys;
`endif

    function automatic logic [CODE_W-1:0] code_of(
        input logic [COL_W-1:0] c,
        input logic [ROWS-1:0]  v
    );
        int r;
        r = 0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return CODE_W'(int'(c) * ROWS + r);
    endfunction

    // Scan sequencing, debounce compare and key table update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        samp_a_d = samp_a_q;
        samp_b_d = samp_b_q;
        stable_d = stable_q;
        valid_d  = 1'b0;
        code_d   = code_q;
        multi_d  = 1'b0;
        new_keys = stable_q[col_q] & ~samp_b_q;
`ifdef KEY_RELEASE_EN
        rel_d      = 1'b0;
        rel_code_d = rel_code_q;
        rel_keys   = ~stable_q[col_q] & samp_b_q;
`endif
        unique case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    samp_a_d = kp.buttonsin;
                    cnt_d    = '0;
                    state_d  = DEBOUNCE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    samp_b_d = kp.buttonsin;
                    cnt_d    = '0;
                    state_d  = EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EVAL: begin
                state_d = SETTLE;
                cnt_d   = '0;
                // A mismatch means the column bounced: retry it unchanged
                if (samp_a_q == samp_b_q) begin
                    stable_d[col_q] = samp_b_q;
                    if (|new_keys) begin
                        valid_d = 1'b1;
                        code_d  = code_of(col_q, new_keys);
                        multi_d = |(new_keys & (new_keys - ROWS'(1)));
                    end
`ifdef KEY_RELEASE_EN
                    if (|rel_keys) begin
                        rel_d      = 1'b1;
                        rel_code_d = code_of(col_q, rel_keys);
                    end
`endif
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
        held_d = ~&stable_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            col_q    <= '0;
            samp_a_q <= '1;
            samp_b_q <= '1;
            stable_q <= '1;
            valid_q  <= 1'b0;
            code_q   <= '0;
            multi_q  <= 1'b0;
            held_q   <= 1'b0;
`ifdef KEY_RELEASE_EN
            rel_q      <= 1'b0;
            rel_code_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            samp_a_q <= samp_a_d;
            samp_b_q <= samp_b_d;
            stable_q <= stable_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            multi_q  <= multi_d;
            held_q   <= held_d;
`ifdef KEY_RELEASE_EN
            rel_q      <= rel_d;
            rel_code_q <= rel_code_d;
`endif
        end
    end

    assign kp.buttonsout = rst ? '1 : ~(COLS'(1) << col_q);
    assign kp.key_valid  = valid_q;
    assign kp.key_code   = code_q;
    assign kp.key_multi  = multi_q;
    assign kp.key_held   = held_q;
`ifdef KEY_RELEASE_EN
    assign kp.key_release      = rel_q;
    assign kp.key_release_code = rel_code_q;
`endif
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner with a keypad model.
// Release reporting is checked when KEY_RELEASE_EN is defined.
module tb_keypad_matrix_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int S    = 2;
    localparam int D    = 8;
    localparam int P    = S + D + 1;

    typedef struct {
        int cyc;
        int code;
        bit multi;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif();

    keypad_matrix_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SETTLE_CYCLES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp(kif)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    ev_t press_q[$];
    ev_t rel_q[$];

    // Physical keypad: keys[c][r] = 1 while that key is held down
    bit keys[COLS][ROWS];

    // Reference: spec-level scan schedule and debounced key table
    bit [ROWS-1:0] st_m[COLS];
    bit [ROWS-1:0] sa, sb;
    int col_m, ph;
    bit held_m;

    function automatic void check(string name, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      name, act, exp, cyc);
    endfunction

    function automatic int lowest(bit [ROWS-1:0] v);
        for (int i = 0; i < ROWS; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [ROWS-1:0] pins();
        logic [ROWS-1:0] b;
        b = '1;
        if (!rst)
            for (int r = 0; r < ROWS; r++) if (keys[col_m][r]) b[r] = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        col_m  = 0;
        ph     = 0;
        held_m = 0;
        for (int c = 0; c < COLS; c++) st_m[c] = '1;
    endtask

    task automatic model_eval();
        bit [ROWS-1:0] nw, rl;
        if (sa != sb) return;
        nw = st_m[col_m] & ~sb;
        rl = ~st_m[col_m] & sb;
        if (nw != 0)
            press_q.push_back('{cyc: cyc + 1,
                                code: col_m * ROWS + lowest(nw),
                                multi: ($countones(nw) > 1)});
        if (rl != 0)
            rel_q.push_back('{cyc: cyc + 1,
                              code: col_m * ROWS + lowest(rl),
                              multi: 1'b0});
        st_m[col_m] = sb;
        col_m = (col_m + 1) % COLS;
        held_m = 0;
        for (int c = 0; c < COLS; c++) if (st_m[c] != '1) held_m = 1;
    endtask

    // One clock cycle: drive pins, check levels, advance the model
    task automatic step();
        logic [ROWS-1:0] bin;
        logic [COLS-1:0] eo;
        bin = pins();
        kif.buttonsin = bin;
        #1;
        eo = '1;
        if (!rst) eo[col_m] = 1'b0;
        check("buttonsout", int'(kif.buttonsout), int'(eo));
        check("key_held", int'(kif.key_held), int'(held_m));
        if (rst) begin
            model_reset();
        end else begin
            if (ph == S - 1) sa = bin;
            if (ph == S + D - 1) sb = bin;
            if (ph == P - 1) model_eval();
            if (!(ph == P - 1 && sa != sb)) ph = (ph + 1) % P;
            else ph = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_for(int c, int p);
        for (int i = 0; i < 3 * COLS * P && !(col_m == c && ph == p); i++)
            step();
        check("wait_phase", col_m * 100 + ph, c * 100 + p);
    endtask

    task automatic clear_keys();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) keys[c][r] = 1'b0;
    endtask

    // Monitor: pops expected reports whenever the DUT pulses
    always @(negedge clk) begin
        ev_t e;
        if (kif.key_valid === 1'b1) begin
            if (press_q.size() == 0) begin
                check("unexpected_key_valid", 1, 0);
            end else begin
                e = press_q.pop_front();
                check("press_cycle", cyc, e.cyc);
                check("key_code", int'(kif.key_code), e.code);
                check("key_multi", int'(kif.key_multi), int'(e.multi));
            end
        end else begin
            if (kif.key_multi === 1'b1) check("stray_key_multi", 1, 0);
            if (press_q.size() > 0 && press_q[0].cyc <= cyc) begin
                e = press_q.pop_front();
                check("missing_key_valid", 0, e.code + 1);
            end
        end
`ifdef KEY_RELEASE_EN
        if (kif.key_release === 1'b1) begin
            if (rel_q.size() == 0) begin
                check("unexpected_key_release", 1, 0);
            end else begin
                e = rel_q.pop_front();
                check("release_cycle", cyc, e.cyc);
                check("key_release_code", int'(kif.key_release_code), e.code);
            end
        end else if (rel_q.size() > 0 && rel_q[0].cyc <= cyc) begin
            e = rel_q.pop_front();
            check("missing_key_release", 0, e.code + 1);
        end
`else
        rel_q.delete();
`endif
    end

    initial begin
        int c, r, r2;
        clear_keys();
        model_reset();
        sa = '1;
        sb = '1;
        kif.buttonsin = '1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run(3);
        check("rst_key_code", int'(kif.key_code), 0);
        check("rst_key_valid", int'(kif.key_valid), 0);
        rst = 1'b0;

        // Idle scan: column walk and wrap
        run(50);

        // Steady press row 2 col 1, held for 10 scans, then released
        keys[1][2] = 1'b1;
        run(10 * COLS * P + P);
        keys[1][2] = 1'b0;
        run(2 * COLS * P);

        // Bounce in column 1: pressed at first sample only
        wait_for(1, 0);
        keys[1][2] = 1'b1;
        run(S);
        keys[1][2] = 1'b0;
        run(3 * P);

        // Rows 0 and 3 together in column 3
        keys[3][0] = 1'b1;
        keys[3][3] = 1'b1;
        run(2 * COLS * P);
        clear_keys();
        run(2 * COLS * P);

        // Randomized presses, sometimes two rows in one column
        for (int i = 0; i < 8; i++) begin
            c = $urandom_range(COLS - 1);
            r = $urandom_range(ROWS - 1);
            keys[c][r] = 1'b1;
            if ($urandom_range(1) == 1) begin
                r2 = $urandom_range(ROWS - 1);
                keys[c][r2] = 1'b1;
            end
            run($urandom_range(30, 150));
            clear_keys();
            run($urandom_range(10, 60));
        end
        run(2 * COLS * P);

        // Reset during debounce with a key down, then re-detect
        wait_for(0, 0);
        keys[2][1] = 1'b1;
        wait_for(2, S + 3);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        check("rst_mid_key_code", int'(kif.key_code), 0);
        check("rst_mid_key_held", int'(kif.key_held), 0);
        run((COLS + 2) * P);
        keys[2][1] = 1'b0;
        run(2 * COLS * P);

        run(P);
        check("press_queue_empty", press_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
